// File: rtl/nmr_vote_recovery.sv
// N-modular-redundancy word voter with per-core fault counting, core retirement and hold/resync sequencing (optional NMR_ERR_LOG_EN adds err_events/last_fault_core).
// Latency: one register stage; a sample presented in cycle k appears on voted_out/out_valid/mismatch_mask in cycle k+1.
// Backpressure: none accepted; core_hold is asserted to stall the cores during RESYNC and FATAL, and in_valid is ignored there.
module nmr_vote_recovery #(
    parameter int NUM_CORES    = 3,
    parameter int WIDTH        = 97,
    parameter int FAULT_THRESH = 4,
    parameter int HOLD_CYCLES  = 2
) (
    input  logic                       clk,
    input  logic                       rst_in,
    input  logic [NUM_CORES*WIDTH-1:0] core_bus,
    input  logic                       in_valid,
    output logic [WIDTH-1:0]           voted_out,
    output logic                       out_valid,
    output logic [NUM_CORES-1:0]       mismatch_mask,
    output logic [NUM_CORES-1:0]       core_disable,
    output logic [NUM_CORES-1:0]       resync_req,
    output logic                       core_hold,
    output logic [1:0]                 state,
    output logic                       fatal
`ifdef NMR_ERR_LOG_EN
    ,
    output logic [15:0]                err_events,
    output logic [$clog2(NUM_CORES)-1:0] last_fault_core
`endif
);

    localparam int CNT_W  = $clog2(FAULT_THRESH + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_VOTE   = 2'b00,
        ST_RESYNC = 2'b01,
        ST_FATAL  = 2'b10
    } state_t;

    state_t                cur_state, nxt_state;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic [CNT_W-1:0]      cnt_q [NUM_CORES];
    logic [CNT_W-1:0]      cnt_d [NUM_CORES];
    logic [WIDTH-1:0]      words [NUM_CORES];
    logic [WIDTH-1:0]      maj_word;
    logic                  maj_found;
    logic [NUM_CORES-1:0]  mismatch, retire, transient;
    logic                  vote, go_fatal, go_resync, forward;
    int                    n_en, n_after, agree;

    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            words[i] = core_bus[i*WIDTH +: WIDTH];
        end
    end

    // Word-level majority among enabled cores; lowest qualifying index wins.
    always_comb begin
        n_en      = 0;
        agree     = 0;
        maj_found = 1'b0;
        maj_word  = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!core_disable[i]) n_en = n_en + 1;
        end
        for (int i = 0; i < NUM_CORES; i++) begin
            agree = 0;
            for (int j = 0; j < NUM_CORES; j++) begin
                if (!core_disable[j] && words[j] == words[i]) agree = agree + 1;
            end
            if (!maj_found && !core_disable[i] && (2 * agree > n_en)) begin
                maj_found = 1'b1;
                maj_word  = words[i];
            end
        end
    end

    always_comb begin
        mismatch  = '0;
        retire    = '0;
        n_after   = n_en;
        for (int i = 0; i < NUM_CORES; i++) begin
            cnt_d[i] = cnt_q[i];
            if (maj_found && !core_disable[i]) begin
                if (words[i] != maj_word) begin
                    mismatch[i] = 1'b1;
                    if (cnt_q[i] != CNT_W'(FAULT_THRESH)) cnt_d[i] = cnt_q[i] + 1'b1;
                    if (int'(cnt_q[i]) + 1 >= FAULT_THRESH) begin
                        retire[i] = 1'b1;
                        n_after   = n_after - 1;
                    end
                end else begin
                    cnt_d[i] = '0;
                end
            end
        end
        transient = mismatch & ~retire;
        vote      = (cur_state == ST_VOTE) && in_valid;
        go_fatal  = vote && (!maj_found || n_after < 2);
        go_resync = vote && !go_fatal && (|transient);
        forward   = vote && !go_fatal;
    end

    always_comb begin
        nxt_state = cur_state;
        hold_d    = hold_q;
        case (cur_state)
            ST_VOTE: begin
                if (go_fatal) begin
                    nxt_state = ST_FATAL;
                end else if (go_resync) begin
                    nxt_state = ST_RESYNC;
                    hold_d    = HOLD_W'(HOLD_CYCLES - 1);
                end
            end
            ST_RESYNC: begin
                if (hold_q == '0) nxt_state = ST_VOTE;
                else              hold_d    = hold_q - 1'b1;
            end
            ST_FATAL: nxt_state = ST_FATAL;
            default:  nxt_state = ST_VOTE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            cur_state     <= ST_VOTE;
            hold_q        <= '0;
            voted_out     <= '0;
            out_valid     <= 1'b0;
            mismatch_mask <= '0;
            core_disable  <= '0;
            resync_req    <= '0;
            for (int i = 0; i < NUM_CORES; i++) cnt_q[i] <= '0;
        end else begin
            cur_state  <= nxt_state;
            hold_q     <= hold_d;
            out_valid  <= forward;
            resync_req <= go_resync ? transient : '0;
            if (forward) begin
                voted_out     <= maj_word;
                mismatch_mask <= mismatch;
            end
            // Retiring cores are dropped in the same update that counts their last miss.
            if (vote && maj_found) begin
                core_disable <= core_disable | retire;
                for (int i = 0; i < NUM_CORES; i++) cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign state     = cur_state;
    assign core_hold = (cur_state != ST_VOTE);
    assign fatal     = (cur_state == ST_FATAL);

`ifdef NMR_ERR_LOG_EN
    localparam int IDX_W = $clog2(NUM_CORES);

    logic [IDX_W-1:0] first_idx;

    always_comb begin
        first_idx = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (mismatch[i]) first_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            err_events      <= '0;
            last_fault_core <= '0;
        end else if (forward && (|mismatch)) begin
            if (err_events != 16'hFFFF) err_events <= err_events + 16'd1;
            last_fault_core <= first_idx;
        end
    end
`endif

endmodule
